// File: rtl/ad9361_spi_pkg.sv
// Shared definitions for the AD9361 SPI responder: FSM states and
// instruction word field positions.
package ad9361_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int INSTR_BITS = 16;
  localparam int RW_BIT     = 15;
  localparam int CNT_MSB    = 14;
  localparam int CNT_LSB    = 12;
  localparam int ADDR_W     = 10;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by an edge-detect stage that produces
// single-cycle rise/fall pulses aligned with the synchronized level.
module spi_sync_edge #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1, s2, prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= INIT;
      s2   <= INIT;
      prev <= INIT;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~prev;
  assign fall = ~s2 & prev;

endmodule

// File: rtl/ad9361_spi_responder.sv
// AD9361-compatible 4-wire SPI responder: oversamples SCK/SS/MOSI, decodes the
// 16-bit instruction and serves byte reads/writes from a local register file.
module ad9361_spi_responder
  import ad9361_spi_pkg::*;
#(
  parameter int         NREGS   = 64,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int          IDX_W   = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned NREGS_U = NREGS;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NREGS_U;
  endfunction

  logic sck_lvl, sck_rise, sck_fall;
  logic ss_q, ss_rise, ss_fall;
  logic mosi_s1, mosi_q;

  spi_sync_edge #(.INIT(1'b0)) u_sck_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sck),
    .q    (sck_lvl),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  // SS resets to the deasserted level so reset never looks like a select.
  spi_sync_edge #(.INIT(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (ss_n),
    .q    (ss_q),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  logic unused_ok;
  assign unused_ok = sck_lvl ^ ss_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_s1 <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      mosi_s1 <= mosi;
      mosi_q  <= mosi_s1;
    end
  end

  assign busy = ~ss_q;

  // A select already low when reset releases must not start a transfer:
  // arm only after a genuine high level has passed the synchronizer.
  logic [1:0] warm;
  logic       armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm  <= 2'd0;
      armed <= 1'b0;
    end else begin
      if (warm != 2'd3) warm <= warm + 2'd1;
      if (warm == 2'd3 && ss_q) armed <= 1'b1;
    end
  end

  state_t              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [2:0]          byte_cnt_q, byte_cnt_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [14:0]         instr_q, instr_d;
  logic [6:0]          rx_q, rx_d;
  logic [7:0]          tx_q, tx_d;
  logic                miso_d, miso_oe_d, stb_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [7:0]          wr_data_d;
  logic [15:0]         instr_full;
  logic [7:0]          rx_full;
  logic [7:0]          rd_byte;
  logic [7:0]          regs [NREGS];

  assign instr_full = {instr_q, mosi_q};
  assign rx_full    = {rx_q, mosi_q};

  always_comb begin
    rd_byte = 8'h00;
    if (in_range(addr_q)) rd_byte = regs[addr_q[IDX_W-1:0]];
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    miso_d     = miso;
    miso_oe_d  = miso_oe;
    stb_d      = 1'b0;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;

    // Deselect has priority over any SCK edge seen in the same cycle.
    if (ss_q) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_fall && armed) begin
            state_d   = INSTR;
            bit_cnt_d = 4'd0;
          end
        end
        INSTR: begin
          if (sck_rise) begin
            instr_d   = instr_full[14:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'(INSTR_BITS - 1)) begin
              state_d    = DATA;
              bit_cnt_d  = 4'd0;
              byte_cnt_d = 3'd0;
              rw_d       = instr_full[RW_BIT];
              cnt_d      = instr_full[CNT_MSB:CNT_LSB];
              addr_d     = instr_full[ADDR_W-1:0];
            end
          end
        end
        DATA: begin
          if (sck_rise) begin
            rx_d = rx_full[6:0];
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              addr_d    = addr_q - 10'd1;
              if (rw_q) begin
                stb_d     = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = rx_full;
              end
              if (byte_cnt_q == cnt_q) begin
                state_d   = DONE;
                miso_d    = 1'b0;
                miso_oe_d = 1'b0;
              end else begin
                byte_cnt_d = byte_cnt_q + 3'd1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else if (sck_fall && !rw_q) begin
            // A fall at bit 0 opens a new byte: fetch it and present its MSB.
            if (bit_cnt_q == 4'd0) begin
              miso_d    = rd_byte[7];
              tx_d      = {rd_byte[6:0], 1'b0};
              miso_oe_d = 1'b1;
            end else begin
              miso_d = tx_q[7];
              tx_d   = {tx_q[6:0], 1'b0};
            end
          end
        end
        DONE: begin
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      byte_cnt_q <= 3'd0;
      cnt_q      <= 3'd0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      instr_q    <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      miso       <= miso_d;
      miso_oe    <= miso_oe_d;
      wr_stb     <= stb_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
    end
  end

  // Strobe reports every committed byte; storage only exists below NREGS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= RST_VAL;
    end else if (wr_stb && in_range(wr_addr)) begin
      regs[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_ad9361_spi_responder.sv
// Directed plus randomized SPI traffic against a byte-array model of the
// responder; strobes are collected by a monitor and matched in order.
module tb_ad9361_spi_responder;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst_n, sck, ss_n, mosi;
  logic       miso, miso_oe, wr_stb, busy;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;

  always #5 clk = ~clk;

  ad9361_spi_responder #(.NREGS(64), .RST_VAL(8'h00)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sck    (sck),
    .ss_n   (ss_n),
    .mosi   (mosi),
    .miso   (miso),
    .miso_oe(miso_oe),
    .wr_stb (wr_stb),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy   (busy)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  model [64];
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  logic [7:0]  wbuf [8];

  always @(negedge clk) begin
    if (rst_n && wr_stb) obs_q.push_back({wr_addr, wr_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [9:0] a);
    return (a < 10'd64) ? model[a[5:0]] : 8'h00;
  endfunction

  task automatic model_wr(input logic [9:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
    if (a < 10'd64) model[a[5:0]] = d;
  endtask

  task automatic spi_bit(input logic b, output logic r, output logic o);
    mosi = b;
    repeat (HALF) @(negedge clk);
    r   = miso;
    o   = miso_oe;
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic check_strobes();
    chk("stb_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk("stb_addr_data", obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic xfer(input logic rw, input int n, input logic [9:0] addr,
                      input int abort_bits, input int extra_bits);
    logic [15:0] instr;
    logic [9:0]  a;
    logic [7:0]  rb, ob;
    logic        r, o, aborted;
    int          sent;
    instr = {rw, 3'(n - 1), 2'b00, addr};
    ss_n  = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 15; i >= 0; i--) spi_bit(instr[i], r, o);
    chk("busy_in_xfer", busy, 1);
    a = addr;
    sent = 0;
    aborted = 1'b0;
    for (int b = 0; b < n && !aborted; b++) begin
      rb = 8'h00;
      ob = 8'h00;
      for (int k = 7; k >= 0; k--) begin
        if (abort_bits >= 0 && sent == abort_bits) aborted = 1'b1;
        if (!aborted) begin
          spi_bit(rw ? wbuf[b][k] : 1'b0, r, o);
          rb[k] = r;
          ob[k] = o;
          sent++;
        end
      end
      if (!aborted) begin
        if (rw) begin
          model_wr(a, wbuf[b]);
          chk("wr_oe_low", ob, 8'h00);
        end else begin
          chk("rd_data", rb, model_rd(a));
          chk("rd_oe_high", ob, 8'hFF);
        end
        a = a - 10'd1;
      end
    end
    for (int i = 0; i < extra_bits; i++) spi_bit(1'($urandom_range(0, 1)), r, o);
    if (extra_bits > 0) chk("done_oe_low", o, 0);
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    repeat (4 * HALF) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_oe", miso_oe, 0);
    check_strobes();
  endtask

  initial begin
    logic [15:0] ri;
    logic        r, o, rw;
    int          n, sel;
    logic [9:0]  a;

    rst_n = 1'b0;
    sck   = 1'b0;
    ss_n  = 1'b1;
    mosi  = 1'b0;
    foreach (model[i]) model[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Single write, then extra SCK bits that DONE must ignore
    wbuf[0] = 8'hA5;
    xfer(1'b1, 1, 10'h005, -1, 8);
    xfer(1'b0, 1, 10'h005, -1, 0);

    // Multi-byte writes crossing the 0x000 -> 0x3FF wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    xfer(1'b1, 2, 10'h001, -1, 0);
    wbuf[0] = 8'h33; wbuf[1] = 8'h44;
    xfer(1'b1, 2, 10'h000, -1, 0);
    xfer(1'b0, 2, 10'h001, -1, 0);

    // Out-of-range reads
    xfer(1'b0, 1, 10'h040, -1, 0);
    xfer(1'b0, 1, 10'h3FF, -1, 0);

    // Abort after 5 data bits, then a full transfer to the same address
    wbuf[0] = 8'hC3;
    xfer(1'b1, 1, 10'h010, 5, 0);
    xfer(1'b0, 1, 10'h010, -1, 0);
    wbuf[0] = 8'h5C;
    xfer(1'b1, 1, 10'h010, -1, 0);
    xfer(1'b0, 1, 10'h010, -1, 0);

    for (int t = 0; t < 16; t++) begin
      foreach (wbuf[i]) wbuf[i] = 8'($urandom_range(0, 255));
      rw  = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 8);
      sel = $urandom_range(0, 3);
      a   = (sel == 3) ? 10'($urandom_range(1016, 1023)) : 10'($urandom_range(0, 70));
      xfer(rw, n, a, -1, $urandom_range(0, 2));
    end
    xfer(1'b0, 8, 10'h03F, -1, 0);

    // Reset in the middle of a read data byte
    ri = 16'h0005;
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 15; i >= 0; i--) spi_bit(ri[i], r, o);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, r, o);
    chk("pre_rst_oe", miso_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_oe", miso_oe, 0);
    chk("midrst_miso", miso, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    repeat (4 * HALF) @(negedge clk);
    foreach (model[i]) model[i] = 8'h00;
    obs_q.delete();
    exp_q.delete();
    xfer(1'b0, 8, 10'h007, -1, 0);
    xfer(1'b0, 8, 10'h017, -1, 0);
    xfer(1'b0, 8, 10'h03F, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
